// File: rtl/conv3x3_stream_engine.sv
// Streaming 3x3 filter: raster-reads a frame from BRAM0 through two line buffers
// and a 3x3 window, writing copy / Sobel / thresholded result to BRAM1.
module conv3x3_stream_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_WIDTH  = 256,
  parameter int DIM_WIDTH  = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [1:0]            i_mode,
  input  logic [DIM_WIDTH-1:0]  i_width,
  input  logic [DIM_WIDTH-1:0]  i_height,
  input  logic [DATA_WIDTH-1:0] i_thresh,
  output logic                  b0_ce,
  output logic [ADDR_WIDTH-1:0] b0_addr,
  input  logic [DATA_WIDTH-1:0] b0_q,
  output logic                  b1_ce,
  output logic                  b1_we,
  output logic [ADDR_WIDTH-1:0] b1_addr,
  output logic [DATA_WIDTH-1:0] b1_d,
  output logic                  o_idle,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);
  localparam int PW  = 2*DIM_WIDTH + 1;
  localparam int LBW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam int SW  = DATA_WIDTH + 3;

  typedef enum logic [2:0] {IDLE, RUN, FLUSH, DRAIN, DONE} state_t;
  state_t state, state_nx;

  logic [DIM_WIDTH-1:0]   cfg_w, cfg_h;
  logic [1:0]             cfg_mode;
  logic [DATA_WIDTH-1:0]  cfg_thr;
  logic [PW-1:0]          cfg_n, p;
  logic [DIM_WIDTH:0]     row;
  logic [DIM_WIDTH-1:0]   col;
  logic [1:0]             drain_cnt;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [2*DIM_WIDTH-1:0] area;
  logic                   start_ok, accept, slot;

  logic                   s1_push, s1_run, s1_wr, s1_border;
  logic [LBW-1:0]         s1_col;
  logic                   s2_wr, s2_border;

  logic [DATA_WIDTH-1:0]  lb0 [MAX_WIDTH];
  logic [DATA_WIDTH-1:0]  lb1 [MAX_WIDTH];
  logic [DATA_WIDTH-1:0]  win [3][3];
  logic [DATA_WIDTH-1:0]  pix, sat, result;
  logic signed [SW-1:0]   gx, gy;
  logic [SW-1:0]          ax, ay, mag;

  assign area     = (2*DIM_WIDTH)'(i_width) * (2*DIM_WIDTH)'(i_height);
  assign start_ok = (i_width >= DIM_WIDTH'(3)) && (i_height >= DIM_WIDTH'(3)) &&
                    (32'(i_width) <= MAX_WIDTH) &&
                    (64'(area) <= (64'd1 << ADDR_WIDTH)) && (i_mode != 2'd3);
  assign accept   = (state == IDLE) && i_start && start_ok;
  assign slot     = (state == RUN) || (state == FLUSH);

  assign b0_ce   = (state == RUN);
  assign b0_addr = (state == RUN) ? ADDR_WIDTH'(p) : '0;
  assign o_idle  = (state == IDLE);
  assign o_busy  = slot || (state == DRAIN);
  assign o_done  = (state == DONE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (p == cfg_n - PW'(1)) state_nx = FLUSH;
      FLUSH:   if (p == cfg_n + PW'(cfg_w)) state_nx = DRAIN;
      DRAIN:   if (drain_cnt == 2'd2) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cfg_w     <= '0;
      cfg_h     <= '0;
      cfg_mode  <= '0;
      cfg_thr   <= '0;
      cfg_n     <= '0;
      p         <= '0;
      row       <= '0;
      col       <= '0;
      drain_cnt <= '0;
      wr_addr   <= '0;
      o_err     <= 1'b0;
      s1_push   <= 1'b0;
      s1_run    <= 1'b0;
      s1_wr     <= 1'b0;
      s1_border <= 1'b0;
      s1_col    <= '0;
      s2_wr     <= 1'b0;
      s2_border <= 1'b0;
      b1_ce     <= 1'b0;
      b1_we     <= 1'b0;
      b1_addr   <= '0;
      b1_d      <= '0;
    end else begin
      state <= state_nx;
      o_err <= (state == IDLE) && i_start && !start_ok;
      if (accept) begin
        cfg_w    <= i_width;
        cfg_h    <= i_height;
        cfg_mode <= i_mode;
        cfg_thr  <= i_thresh;
        cfg_n    <= PW'(area);
        p        <= '0;
        row      <= '0;
        col      <= '0;
        wr_addr  <= '0;
      end
      if (slot) begin
        p <= p + PW'(1);
        if (col == cfg_w - DIM_WIDTH'(1)) begin
          col <= '0;
          row <= row + (DIM_WIDTH+1)'(1);
        end else begin
          col <= col + DIM_WIDTH'(1);
        end
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      // Slot (row,col) centres the window on (row-1,col-1); col==0 wraps to the
      // previous row's last column, which is always a border output.
      s1_push   <= slot;
      s1_run    <= (state == RUN);
      s1_col    <= LBW'(col);
      s1_wr     <= slot && ((row >= (DIM_WIDTH+1)'(2)) ||
                            (row == (DIM_WIDTH+1)'(1) && col != '0));
      s1_border <= (col <= DIM_WIDTH'(1)) || (row == (DIM_WIDTH+1)'(1)) ||
                   (row == {1'b0, cfg_h});
      s2_wr     <= s1_push && s1_wr;
      s2_border <= s1_border;
      b1_ce     <= s2_wr;
      b1_we     <= s2_wr;
      b1_addr   <= s2_wr ? wr_addr : '0;
      b1_d      <= s2_wr ? result : '0;
      if (s2_wr) wr_addr <= wr_addr + ADDR_WIDTH'(1);
    end
  end

  // BRAM0 data arrives the cycle after the read; flush slots push zeros.
  assign pix = s1_run ? b0_q : '0;

  always_ff @(posedge clk) begin
    if (s1_push) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2]   <= lb1[s1_col];
      win[1][2]   <= lb0[s1_col];
      win[2][2]   <= pix;
      lb1[s1_col] <= lb0[s1_col];
      lb0[s1_col] <= pix;
    end
  end

  always_comb begin
    gx = (SW'(win[0][2]) + (SW'(win[1][2]) << 1) + SW'(win[2][2]))
       - (SW'(win[0][0]) + (SW'(win[1][0]) << 1) + SW'(win[2][0]));
    gy = (SW'(win[2][0]) + (SW'(win[2][1]) << 1) + SW'(win[2][2]))
       - (SW'(win[0][0]) + (SW'(win[0][1]) << 1) + SW'(win[0][2]));
    ax  = gx[SW-1] ? SW'(-gx) : SW'(gx);
    ay  = gy[SW-1] ? SW'(-gy) : SW'(gy);
    mag = ax + ay;
    sat = (|mag[SW-1:DATA_WIDTH]) ? '1 : mag[DATA_WIDTH-1:0];
    result = '0;
    if (cfg_mode == 2'd0)      result = win[1][1];
    else if (s2_border)        result = '0;
    else if (cfg_mode == 2'd1) result = sat;
    else                       result = (mag >= SW'(cfg_thr)) ? '1 : '0;
  end
endmodule

// File: tb/tb_conv3x3_stream_engine.sv
// Bench for conv3x3_stream_engine: BRAM models, table of frames plus random frames
// checked against a per-pixel reference model, and reset/busy/reject sequences.
module tb_conv3x3_stream_engine;
  localparam int DW  = 8;
  localparam int AW  = 16;
  localparam int MW  = 256;
  localparam int DMW = 9;

  logic           clk      = 1'b0;
  logic           rst_n    = 1'b0;
  logic           i_start  = 1'b0;
  logic [1:0]     i_mode   = '0;
  logic [DMW-1:0] i_width  = '0;
  logic [DMW-1:0] i_height = '0;
  logic [DW-1:0]  i_thresh = '0;
  logic           b0_ce;
  logic [AW-1:0]  b0_addr;
  logic [DW-1:0]  b0_q;
  logic           b1_ce, b1_we;
  logic [AW-1:0]  b1_addr;
  logic [DW-1:0]  b1_d;
  logic           o_idle, o_busy, o_done, o_err;

  conv3x3_stream_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WIDTH(MW), .DIM_WIDTH(DMW)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_mode(i_mode),
    .i_width(i_width), .i_height(i_height), .i_thresh(i_thresh),
    .b0_ce(b0_ce), .b0_addr(b0_addr), .b0_q(b0_q),
    .b1_ce(b1_ce), .b1_we(b1_we), .b1_addr(b1_addr), .b1_d(b1_d),
    .o_idle(o_idle), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  // clock / BRAM models
  always #5 clk = ~clk;

  logic [DW-1:0] mem0 [65536];
  logic [DW-1:0] mem1 [65536];
  always @(posedge clk) if (b0_ce) b0_q <= mem0[b0_addr];

  // scoreboard state
  logic [DW-1:0] exp_q[$];
  int n_checks = 0, n_pass = 0;
  int cyc = 0, exp_addr = 0, wr_cnt = 0, rd_cnt = 0, done_cnt = 0, err_cnt = 0;
  int first_rd_cyc = 0, first_wr_cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (b0_ce) begin
        if (rd_cnt == 0) first_rd_cyc = cyc;
        rd_cnt++;
      end
      if (b1_we) begin
        if (wr_cnt == 0) first_wr_cyc = cyc;
        if (exp_q.size() == 0) check("unexpected_write", int'(b1_we), 0);
        else begin
          check("wr_addr", int'(b1_addr), exp_addr);
          check("wr_data", int'(b1_d), int'(exp_q.pop_front()));
          check("wr_ce", int'(b1_ce), 1);
        end
        mem1[b1_addr] = b1_d;
        exp_addr++;
        wr_cnt++;
      end else begin
        check("quiet_bus", int'(b1_ce) + int'(b1_d), 0);
      end
      if (o_done) done_cnt++;
      if (o_err) err_cnt++;
    end
  end

  // reference model: whole-frame per-pixel arithmetic on the image in mem0
  function automatic int px(input int w, input int x, input int y);
    return int'(mem0[y*w + x]);
  endfunction

  task automatic build_expected(input int mode, input int w, input int h, input int thr);
    exp_q.delete();
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        int gx, gy, mag;
        logic [DW-1:0] v;
        if (mode == 0) v = mem0[y*w + x];
        else if (x == 0 || y == 0 || x == w-1 || y == h-1) v = '0;
        else begin
          gx = (px(w,x+1,y-1) + 2*px(w,x+1,y) + px(w,x+1,y+1))
             - (px(w,x-1,y-1) + 2*px(w,x-1,y) + px(w,x-1,y+1));
          gy = (px(w,x-1,y+1) + 2*px(w,x,y+1) + px(w,x+1,y+1))
             - (px(w,x-1,y-1) + 2*px(w,x,y-1) + px(w,x+1,y-1));
          mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
          if (mag > 255) mag = 255;
          if (mode == 2) v = (mag >= thr) ? 8'hFF : 8'h00;
          else v = DW'(mag);
        end
        exp_q.push_back(v);
      end
    end
  endtask

  task automatic fill_image(input int kind, input int w, input int h);
    for (int a = 0; a < w*h; a++) begin
      case (kind)
        0:       mem0[a] = DW'(a);
        1:       mem0[a] = 8'h40;
        2:       mem0[a] = ((a % w) >= 2) ? 8'hFF : 8'h00;
        default: mem0[a] = DW'($urandom_range(0, 255));
      endcase
    end
  endtask

  // driver tasks
  task automatic clear_sb();
    exp_addr = 0; wr_cnt = 0; rd_cnt = 0; done_cnt = 0; err_cnt = 0;
    first_rd_cyc = 0; first_wr_cyc = -1000;
  endtask

  task automatic start_pulse(input int mode, input int w, input int h, input int thr);
    @(posedge clk); #1;
    i_mode = 2'(mode); i_width = DMW'(w); i_height = DMW'(h); i_thresh = DW'(thr);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic finish_frame(input int w, input int h);
    for (int k = 0; k < w*h + w + 40 && done_cnt == 0; k++) @(posedge clk);
    check("done_seen", done_cnt, 1);
    repeat (3) @(posedge clk);
    #1;
    check("write_count", wr_cnt, w*h);
    check("read_count", rd_cnt, w*h);
    check("done_pulses", done_cnt, 1);
    check("err_pulses", err_cnt, 0);
    check("exp_left", exp_q.size(), 0);
    check("first_write_latency", first_wr_cyc - first_rd_cyc, w + 4);
    check("idle_after", int'(o_idle), 1);
    check("busy_after", int'(o_busy), 0);
  endtask

  task automatic run_frame(input int mode, input int w, input int h, input int thr);
    build_expected(mode, w, h, thr);
    clear_sb();
    start_pulse(mode, w, h, thr);
    finish_frame(w, h);
  endtask

  task automatic run_reject(input int mode, input int w, input int h);
    clear_sb();
    start_pulse(mode, w, h, 0);
    check("err_pulse", int'(o_err), 1);
    check("idle_on_reject", int'(o_idle), 1);
    repeat (4) @(posedge clk);
    #1;
    check("err_cleared", int'(o_err), 0);
    check("err_count", err_cnt, 1);
    check("reject_reads", rd_cnt, 0);
    check("reject_writes", wr_cnt, 0);
    check("reject_idle", int'(o_idle), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_b0_ce"}, int'(b0_ce), 0);
    check({tag, "_b0_addr"}, int'(b0_addr), 0);
    check({tag, "_b1_ce"}, int'(b1_ce), 0);
    check({tag, "_b1_we"}, int'(b1_we), 0);
    check({tag, "_b1_addr"}, int'(b1_addr), 0);
    check({tag, "_b1_d"}, int'(b1_d), 0);
    check({tag, "_done"}, int'(o_done), 0);
    check({tag, "_err"}, int'(o_err), 0);
    check({tag, "_idle"}, int'(o_idle), 1);
    check({tag, "_busy"}, int'(o_busy), 0);
  endtask

  typedef struct {
    int mode; int w; int h; int thr; int img; bit ok;
    int spot_a; int spot_av; int spot_b; int spot_bv;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{0, 5, 4, 0,    0, 1'b1, 13, 13, 19, 19});
    vecs.push_back('{1, 6, 5, 0,    1, 1'b1,  8,  0,  0,  0});
    vecs.push_back('{1, 5, 5, 0,    2, 1'b1,  6, 255, 8,  0});
    vecs.push_back('{2, 8, 4, 8'h80, 0, 1'b1, 9,  0, 10,  0});
    vecs.push_back('{2, 8, 4, 8,    0, 1'b1,  9, 255, 10, 255});
    vecs.push_back('{0, 3, 3, 0,    3, 1'b1, -1,  0, -1,  0});
    vecs.push_back('{1, 256, 3, 0,  3, 1'b1, -1,  0, -1,  0});
    vecs.push_back('{0, 2, 5, 0,    0, 1'b0, -1,  0, -1,  0});
    vecs.push_back('{3, 5, 5, 0,    0, 1'b0, -1,  0, -1,  0});
    vecs.push_back('{1, 5, 2, 0,    0, 1'b0, -1,  0, -1,  0});
    vecs.push_back('{1, 257, 3, 0,  0, 1'b0, -1,  0, -1,  0});
    vecs.push_back('{2, 256, 257, 0, 0, 1'b0, -1, 0, -1,  0});

    // reset block
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].ok) begin
        fill_image(vecs[i].img, vecs[i].w, vecs[i].h);
        run_frame(vecs[i].mode, vecs[i].w, vecs[i].h, vecs[i].thr);
        if (vecs[i].spot_a >= 0) check("spot_a", int'(mem1[vecs[i].spot_a]), vecs[i].spot_av);
        if (vecs[i].spot_b >= 0) check("spot_b", int'(mem1[vecs[i].spot_b]), vecs[i].spot_bv);
      end else begin
        run_reject(vecs[i].mode, vecs[i].w, vecs[i].h);
      end
    end

    for (int k = 0; k < 6; k++) begin
      int m, w, h, t;
      m = $urandom_range(0, 2);
      w = $urandom_range(3, 12);
      h = $urandom_range(3, 8);
      t = $urandom_range(0, 255);
      fill_image(3, w, h);
      run_frame(m, w, h, t);
    end

    // start while busy is ignored
    fill_image(3, 6, 4);
    build_expected(0, 6, 4, 0);
    clear_sb();
    start_pulse(0, 6, 4, 0);
    repeat (8) @(posedge clk);
    start_pulse(1, 3, 3, 0);
    finish_frame(6, 4);

    // reset in the middle of a frame
    fill_image(3, 7, 5);
    build_expected(1, 7, 5, 0);
    clear_sb();
    start_pulse(1, 7, 5, 0);
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("midrun_reset");
    exp_q.delete();
    clear_sb();
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("post_reset_writes", wr_cnt, 0);
    check("post_reset_reads", rd_cnt, 0);
    check("post_reset_idle", int'(o_idle), 1);
    fill_image(3, 7, 5);
    run_frame(1, 7, 5, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
